mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Multicycle control FSM that sequences the 16-bit-instruction / 8-bit-data datapath over a shared, variable-latency memory port.
- Latches the fetched instruction via irwrite.
- Decodes opcode/funct and holds the datapath control word steady for the whole instruction.
- Issues exactly one PC update per instruction.
- Sits between the top level, the datapath and the memory interface.

Parameters:
WAIT_MAX, 15, max cycles to wait for mem_ready before bus-error halt (1..255)
OP_W, 3, opcode width (instr[15:13])

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instr  input  16  instruction register contents (valid from S_DECODE on)
zero  input  1  ALU zero flag from datapath
mem_ready  input  1  memory completes current read/write this cycle
memread  output  1  memory read request (fetch or load)
memwrite  output  1  memory write request (store)
iord  output  1  0 = address from PC (fetch), 1 = address from aluout (data)
irwrite  output  1  latch readdata into instruction register
pcwrite  output  1  load pcnext into PC
pcsrc  output  1  select branch target
jump  output  1  select jump target
regwrite  output  1  register file write enable
regdst  output  1  write reg from instr[2:0] (R-type) vs instr[8:6]
alusrc  output  1  ALU B = zero-extended instr[6:0]
memtoreg  output  1  writeback from readdata
alucontrol  output  3  ALU operation
halted  output  1  FSM parked in S_HALT
buserr  output  1  halt caused by memory timeout
illegal  output  1  halt caused by undefined opcode/funct

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - State goes to S_FETCH; wait counter is cleared.
  - All outputs are 0 while reset is asserted and in the first S_FETCH cycle, except memread=1 once reset is released.
  - Reset mid-instruction abandons it with no PC or register write.
- Opcodes, op = instr[15:13]:
  - 000 RTYPE; funct = instr[5:3]: 000 add, 001 sub, 010 and, 011 or, 100 slt, others illegal.
  - 001 LB, 010 SB, 011 BEQ, 100 ADDI, 101 J, 111 HALT.
  - 110 is illegal.
- alucontrol codes: add=010, sub=110, and=000, or=001, slt=111. LB/SB/ADDI use add; BEQ uses sub.
- S_FETCH:
  - Drives memread=1, iord=0 until mem_ready.
  - On mem_ready: irwrite=1 for that cycle, then go to S_DECODE.
- S_DECODE (1 cycle):
  - Registers the control word; it is held through the last state of the instruction.
  - J: pcwrite=1, jump=1, then S_FETCH.
  - HALT or illegal: go to S_HALT; illegal sets the illegal flag.
  - Otherwise go to S_EXEC.
- S_EXEC (1 cycle):
  - RTYPE/ADDI: go to S_WB.
  - LB/SB: go to S_MEM.
  - BEQ: pcwrite=1, pcsrc=zero, then S_FETCH.
- S_MEM:
  - LB: memread=1, iord=1; on mem_ready go to S_WB.
  - SB: memwrite=1, iord=1; on mem_ready pcwrite=1, then S_FETCH.
- S_WB (1 cycle):
  - regwrite=1 and pcwrite=1 (pcsrc=0, jump=0).
  - RTYPE: regdst=1. LB: memtoreg=1. ADDI: alusrc=1.
  - Then S_FETCH.
- PC rule: pcwrite is asserted in exactly one cycle per retired instruction, always the last state of that instruction; the PC is stable during all earlier states.
- Latency with zero-wait memory (mem_ready same cycle as request):
  - J = 2 cycles, BEQ = 3, RTYPE/ADDI = 4, SB = 4, LB = 5.
  - Each memory wait cycle adds 1.
- Memory handshake:
  - memread/memwrite stay constant until mem_ready.
  - mem_ready outside S_FETCH/S_MEM is ignored.
  - memread and memwrite are never both high.
- Timeout:
  - An 8-bit wait counter increments each request cycle without mem_ready and clears on mem_ready.
  - If it reaches WAIT_MAX, go to S_HALT with buserr=1 and no PC/register write.
- S_HALT: terminal until reset. halted=1; every enable output is 0; buserr/illegal hold their values.

Optional Feature:
- Macro MC_CTRL_PERFCNT_EN.
- Defined:
  - Extra outputs instret[15:0] and stallcnt[15:0], both reset to 0.
  - instret increments on each pcwrite.
  - stallcnt increments on each cycle a memory request is stalled (no mem_ready).
  - Both counters wrap at 16'hFFFF to 0 and freeze in S_HALT.
- Not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mc_pkg holds:
  - state enum (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT);
  - opcode and funct localparams;
  - alucontrol code localparams;
  - a packed control-word struct.
- Sub-module mc_aludec: combinational op/funct to alucontrol plus illegal flag.
- The FSM and wait counter stay in mc_controller.

Test Plan:
- Zero-wait ADDI, instr=16'h8085 -> 4 cycles. irwrite in cycle 1; alusrc=1 with alucontrol=010 in cycles 3-4; regwrite=1 and pcwrite=1 only in cycle 4.
- LB with mem_ready delayed 3 cycles in S_MEM -> memread=1, iord=1 held 4 cycles. Then S_WB with memtoreg=1, regwrite=1; total 8 cycles; exactly one pcwrite.
- BEQ with zero=1, then BEQ with zero=0 -> both 3 cycles. pcwrite=1 in cycle 3 both times; pcsrc=1 then pcsrc=0; regwrite never asserted.
- J then opcode 110 -> J: pcwrite=1, jump=1 in cycle 2. Opcode 110: illegal=1, halted=1 from cycle 3, all enables 0 for 20 further cycles.
- mem_ready held 0 in S_FETCH with WAIT_MAX=15 -> buserr=1, halted=1 after 15 cycles; no irwrite or pcwrite.
- Reset asserted mid-S_MEM of SB -> memwrite drops asynchronously. After release: S_FETCH with memread=1; no pcwrite for the aborted SB (and instret unchanged if MC_CTRL_PERFCNT_EN).

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller: state encoding,
// opcode/funct/ALU code tables and the registered control word.
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [2:0] OP_RTYPE = 3'b000;
   localparam logic [2:0] OP_LB    = 3'b001;
   localparam logic [2:0] OP_SB    = 3'b010;
   localparam logic [2:0] OP_BEQ   = 3'b011;
   localparam logic [2:0] OP_ADDI  = 3'b100;
   localparam logic [2:0] OP_J     = 3'b101;
   localparam logic [2:0] OP_ILL   = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   localparam logic [2:0] F_ADD = 3'b000;
   localparam logic [2:0] F_SUB = 3'b001;
   localparam logic [2:0] F_AND = 3'b010;
   localparam logic [2:0] F_OR  = 3'b011;
   localparam logic [2:0] F_SLT = 3'b100;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Captured in S_DECODE and held until the instruction retires.
   typedef struct packed {
      logic [2:0] op;
      logic [2:0] aluctl;
      logic       regdst;
      logic       alusrc;
      logic       memtoreg;
   } ctrl_t;

endpackage

// File: rtl/mc_aludec.sv
// Combinational opcode/funct decoder: ALU operation plus undefined-encoding flag.
import mc_pkg::*;

module mc_aludec (
   input  logic [2:0] op_i,
   input  logic [2:0] funct_i,
   output logic [2:0] alucontrol_o,
   output logic       illegal_o
);

   always_comb begin
      alucontrol_o = ALU_ADD;
      illegal_o    = 1'b0;
      case (op_i)
         OP_RTYPE: begin
            case (funct_i)
               F_ADD:   alucontrol_o = ALU_ADD;
               F_SUB:   alucontrol_o = ALU_SUB;
               F_AND:   alucontrol_o = ALU_AND;
               F_OR:    alucontrol_o = ALU_OR;
               F_SLT:   alucontrol_o = ALU_SLT;
               default: illegal_o    = 1'b1;
            endcase
         end
         OP_BEQ:  alucontrol_o = ALU_SUB;
         OP_ILL:  illegal_o    = 1'b1;
         default: alucontrol_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM over a shared variable-latency memory port, with bus
// timeout. Optional perf counters (instret/stallcnt) under MC_CTRL_PERFCNT_EN.
import mc_pkg::*;

module mc_controller #(
   parameter int WAIT_MAX = 15,
   parameter int OP_W     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        memread,
   output logic        memwrite,
   output logic        iord,
   output logic        irwrite,
   output logic        pcwrite,
   output logic        pcsrc,
   output logic        jump,
   output logic        regwrite,
   output logic        regdst,
   output logic        alusrc,
   output logic        memtoreg,
   output logic [2:0]  alucontrol,
   output logic        halted,
   output logic        buserr,
   output logic        illegal
`ifdef MC_CTRL_PERFCNT_EN
   ,
   output logic [15:0] instret,
   output logic [15:0] stallcnt
`endif
);

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

   state_t          state_q, state_d;
   ctrl_t           ctrl_q, ctrl_d;
   logic [7:0]      wait_q, wait_d, wait_inc;
   logic            buserr_q, buserr_d, illegal_q, illegal_d;
   logic [OP_W-1:0] op;
   logic [2:0]      dec_alu;
   logic            dec_ill;
   logic            mem_req, stall;
   logic            unused_instr;

   assign op           = instr[15 -: OP_W];
   assign unused_instr = ^{instr[12:6], instr[2:0]};
   assign mem_req      = (state_q == S_FETCH) || (state_q == S_MEM);
   assign stall        = mem_req && !mem_ready && !reset;
   assign wait_inc     = wait_q + 8'd1;

   mc_aludec u_aludec (
      .op_i        (op),
      .funct_i     (instr[5:3]),
      .alucontrol_o(dec_alu),
      .illegal_o   (dec_ill)
   );

   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      wait_d    = wait_q;
      buserr_d  = buserr_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH: if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            ctrl_d.op       = op;
            ctrl_d.aluctl   = dec_alu;
            ctrl_d.regdst   = (op == OP_RTYPE);
            ctrl_d.alusrc   = (op == OP_ADDI);
            ctrl_d.memtoreg = (op == OP_LB);
            if (dec_ill) begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end else if (op == OP_HALT) state_d = S_HALT;
            else if (op == OP_J)        state_d = S_FETCH;
            else                        state_d = S_EXEC;
         end
         S_EXEC: begin
            case (ctrl_q.op)
               OP_RTYPE, OP_ADDI: state_d = S_WB;
               OP_LB, OP_SB:      state_d = S_MEM;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEM:   if (mem_ready) state_d = (ctrl_q.op == OP_LB) ? S_WB : S_FETCH;
         S_WB:    state_d = S_FETCH;
         default: state_d = S_HALT;
      endcase
      // Timeout overrides the normal request progression.
      if (mem_req) begin
         if (mem_ready) wait_d = 8'd0;
         else begin
            wait_d = wait_inc;
            if (wait_inc == WAIT_LIM) begin
               state_d  = S_HALT;
               buserr_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         ctrl_q    <= '0;
         wait_q    <= 8'd0;
         buserr_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         wait_q    <= wait_d;
         buserr_q  <= buserr_d;
         illegal_q <= illegal_d;
      end
   end

   // Strobes depend on mem_ready in the same cycle so zero-wait memory costs nothing.
   always_comb begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      pcsrc      = 1'b0;
      jump       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      alusrc     = 1'b0;
      memtoreg   = 1'b0;
      alucontrol = 3'b000;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               memread = 1'b1;
               irwrite = mem_ready;
            end
            S_DECODE: if (op == OP_J) begin
               pcwrite = 1'b1;
               jump    = 1'b1;
            end
            S_EXEC: if (ctrl_q.op == OP_BEQ) begin
               pcwrite = 1'b1;
               pcsrc   = zero;
            end
            S_MEM: begin
               iord     = 1'b1;
               memread  = (ctrl_q.op == OP_LB);
               memwrite = (ctrl_q.op == OP_SB);
               pcwrite  = (ctrl_q.op == OP_SB) && mem_ready;
            end
            S_WB: begin
               regwrite = 1'b1;
               pcwrite  = 1'b1;
            end
            default: ;
         endcase
         if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            alucontrol = ctrl_q.aluctl;
            regdst     = ctrl_q.regdst;
            alusrc     = ctrl_q.alusrc;
            memtoreg   = ctrl_q.memtoreg;
         end
      end
   end

   assign halted  = (state_q == S_HALT);
   assign buserr  = buserr_q;
   assign illegal = illegal_q;

`ifdef MC_CTRL_PERFCNT_EN
   logic [15:0] instret_q, stallcnt_q;

   // Neither pcwrite nor stall can occur in S_HALT, so both counters freeze there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_q  <= 16'd0;
         stallcnt_q <= 16'd0;
      end else begin
         if (pcwrite) instret_q  <= instret_q + 16'd1;
         if (stall)   stallcnt_q <= stallcnt_q + 16'd1;
      end
   end

   assign instret  = instret_q;
   assign stallcnt = stallcnt_q;
`else
   logic unused_stall;
   assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the driver pushes per-instruction
// expectations from a behavioural model, the monitor checks each retire/halt.
module tb_mc_controller;

   localparam int WM = 15;
   localparam logic [2:0] RT = 3'd0, LB = 3'd1, SB = 3'd2, BEQ = 3'd3,
                          ADDI = 3'd4, JMP = 3'd5, ILL = 3'd6, HLT = 3'd7;

   logic        clk, reset, zero, mem_ready;
   logic [15:0] instr;
   logic        memread, memwrite, iord, irwrite, pcwrite, pcsrc, jump;
   logic        regwrite, regdst, alusrc, memtoreg, halted, buserr, illegal;
   logic [2:0]  alucontrol;
`ifdef MC_CTRL_PERFCNT_EN
   logic [15:0] instret, stallcnt;
`endif

   mc_controller #(.WAIT_MAX(WM), .OP_W(3)) dut (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
      .pcwrite(pcwrite), .pcsrc(pcsrc), .jump(jump), .regwrite(regwrite),
      .regdst(regdst), .alusrc(alusrc), .memtoreg(memtoreg), .alucontrol(alucontrol),
      .halted(halted), .buserr(buserr), .illegal(illegal)
`ifdef MC_CTRL_PERFCNT_EN
      , .instret(instret), .stallcnt(stallcnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int halt, lat;
      int pcsrc, jump, regwrite, regdst, alusrc, memtoreg, aluc;
      int nrd, nwr, niord, nir, nreg;
      int buserr, illegal;
   } exp_t;

   exp_t exp_q[$];
   int   nchk = 0, nerr = 0;
   int   nret = 0, exp_stall = 0;
   bit   after_reset = 0;

   function automatic void chk(input string name, input int act, input int expv);
      nchk++;
      if (act != expv) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endfunction

   function automatic int alu_of(input logic [2:0] op, input logic [2:0] fn);
      if (op == BEQ) return 3'b110;
      if (op != RT) return 3'b010;
      case (fn)
         3'd0: return 3'b010;
         3'd1: return 3'b110;
         3'd2: return 3'b000;
         3'd3: return 3'b001;
         default: return 3'b111;
      endcase
   endfunction

   task automatic step(input bit mr);
      mem_ready = mr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset       = 1'b0;
      after_reset = 1'b1;
      exp_stall   = 0;
   endtask

   task automatic run_instr(input logic [2:0] op, input logic [2:0] fn, input bit z,
                            input int fw_in, input int mw);
      exp_t e;
      logic [15:0] w;
      int fw;
      bit ill, hlt, mem;
      fw = fw_in;
      if (after_reset && fw == 0) fw = 1;
      after_reset = 0;
      w = 16'($urandom);
      w[15:13] = op;
      w[5:3]   = fn;
      instr = w;
      zero  = z;
      ill = (op == ILL) || (op == RT && fn > 3'd4);
      hlt = ill || (op == HLT);
      mem = (op == LB) || (op == SB);
      e = '{default: 0};
      e.nrd = fw + 1;
      e.nir = 1;
      if (hlt) begin
         e.halt = 1; e.lat = fw + 3; e.illegal = int'(ill);
      end else begin
         e.aluc = alu_of(op, fn);
         case (op)
            JMP: begin e.lat = fw + 2; e.jump = 1; e.aluc = 0; end
            BEQ: begin e.lat = fw + 3; e.pcsrc = int'(z); end
            RT, ADDI: begin
               e.lat = fw + 4; e.regwrite = 1; e.nreg = 1;
               e.regdst = int'(op == RT); e.alusrc = int'(op == ADDI);
            end
            LB: begin
               e.lat = fw + mw + 5; e.regwrite = 1; e.nreg = 1; e.memtoreg = 1;
               e.nrd = fw + mw + 2; e.niord = mw + 1;
            end
            default: begin e.lat = fw + mw + 4; e.nwr = mw + 1; e.niord = mw + 1; end
         endcase
      end
      exp_q.push_back(e);
      exp_stall += fw + (mem ? mw : 0);
      repeat (fw) step(0);
      step(1);
      step(bit'($urandom_range(1)));
      if (hlt) begin
         repeat (20) step(bit'($urandom_range(1)));
         do_reset();
         return;
      end
      if (op == JMP) return;
      step(bit'($urandom_range(1)));
      if (op == BEQ) return;
      if (mem) begin
         repeat (mw) step(0);
         step(1);
      end
      if (op != SB) step(bit'($urandom_range(1)));
   endtask

   task automatic run_timeout_fetch();
      exp_t e;
      e = '{default: 0};
      e.halt = 1; e.lat = WM + 1; e.buserr = 1; e.nrd = WM;
      exp_q.push_back(e);
      after_reset = 0;
      instr = 16'($urandom);
      repeat (WM + 20) step(0);
      do_reset();
   endtask

   task automatic run_timeout_lb(input int fw);
      exp_t e;
      e = '{default: 0};
      e.halt = 1; e.lat = fw + WM + 4; e.buserr = 1;
      e.nrd = fw + 1 + WM; e.niord = WM; e.nir = 1;
      exp_q.push_back(e);
      after_reset = 0;
      instr = {LB, 13'($urandom)};
      repeat (fw) step(0);
      step(1);
      step(1);
      step(1);
      repeat (WM + 20) step(0);
      do_reset();
   endtask

   // Monitor: accumulates per-instruction activity, pops on pcwrite or halt entry.
   initial begin
      exp_t e;
      logic [16:0] v;
      int cyc = 0, nrd = 0, nwr = 0, niord = 0, nir = 0, nreg = 0, both = 0;
      int hbad = 0, hn = 0;
      bit first = 0, in_halt = 0;
      logic hb = 0, hi = 0;
      forever begin
         @(negedge clk);
         v = {memread, memwrite, iord, irwrite, pcwrite, pcsrc, jump, regwrite,
              regdst, alusrc, memtoreg, alucontrol, halted, buserr, illegal};
         if (reset) begin
            chk("reset_outputs", int'(v), 0);
            if (in_halt) begin
               chk("halt_quiet", hbad, 0);
               chk("halt_len_ge20", int'(hn >= 20), 1);
            end
            cyc = 0; nrd = 0; nwr = 0; niord = 0; nir = 0; nreg = 0; both = 0;
            in_halt = 0; first = 1; nret = 0;
         end else if (in_halt) begin
            hn++;
            if (v[16:6] != 11'd0 || !halted || buserr != hb || illegal != hi) hbad++;
         end else begin
            if (first) begin
               chk("first_fetch_outputs", int'(v), 'h10000);
               first = 0;
            end
            cyc++;
            nrd += int'(memread); nwr += int'(memwrite); niord += int'(iord);
            nir += int'(irwrite); nreg += int'(regwrite);
            if (memread && memwrite) both++;
            if (halted || pcwrite) begin
               if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("event_is_halt", int'(halted), e.halt);
                  chk("latency", cyc, e.lat);
                  chk("memread_cycles", nrd, e.nrd);
                  chk("memwrite_cycles", nwr, e.nwr);
                  chk("iord_cycles", niord, e.niord);
                  chk("irwrite_cycles", nir, e.nir);
                  chk("regwrite_cycles", nreg, e.nreg);
                  chk("rd_wr_overlap", both, 0);
                  if (halted) begin
                     chk("buserr", int'(buserr), e.buserr);
                     chk("illegal", int'(illegal), e.illegal);
                     in_halt = 1; hb = buserr; hi = illegal; hn = 1;
                     hbad = (v[16:6] != 11'd0) ? 1 : 0;
                  end else begin
                     chk("pcsrc", int'(pcsrc), e.pcsrc);
                     chk("jump", int'(jump), e.jump);
                     chk("regwrite", int'(regwrite), e.regwrite);
                     chk("regdst", int'(regdst), e.regdst);
                     chk("alusrc", int'(alusrc), e.alusrc);
                     chk("memtoreg", int'(memtoreg), e.memtoreg);
                     chk("alucontrol", int'(alucontrol), e.aluc);
                     nret++;
                  end
               end
               cyc = 0; nrd = 0; nwr = 0; niord = 0; nir = 0; nreg = 0; both = 0;
            end
         end
      end
   end

   initial begin
      reset = 1'b1; mem_ready = 1'b0; instr = 16'h0; zero = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      after_reset = 1'b1;

      run_instr(JMP, 3'd0, 1'b0, 1, 0);
      instr = 16'h8085;
      run_instr(ADDI, 3'b000, 1'b0, 0, 0);
      run_instr(LB, 3'd0, 1'b0, 0, 3);
      run_instr(BEQ, 3'd0, 1'b1, 0, 0);
      run_instr(BEQ, 3'd0, 1'b0, 0, 0);
      run_instr(SB, 3'd0, 1'b0, 0, 0);
      run_instr(RT, 3'd4, 1'b0, WM - 1, 0);
      run_instr(SB, 3'd0, 1'b1, 2, WM - 1);
      for (int k = 0; k < 40; k++)
         run_instr(3'($urandom_range(5)), 3'($urandom_range(4)), bit'($urandom_range(1)),
                   $urandom_range(4), $urandom_range(4));

      // Store aborted by reset while waiting in S_MEM: nothing may retire.
      after_reset = 0;
      instr = {SB, 13'($urandom)};
      step(0); step(1); step(1); step(0); step(0); step(0);
      chk("sb_memwrite_before_reset", int'(memwrite), 1);
      #1 reset = 1'b1;
      #1;
      chk("sb_memwrite_async_drop", int'(memwrite), 0);
      chk("sb_pcwrite_in_reset", int'(pcwrite), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0; after_reset = 1'b1; exp_stall = 0;

      run_instr(JMP, 3'd0, 1'b0, 0, 0);
      run_instr(ILL, 3'd0, 1'b0, 0, 0);
      run_timeout_fetch();
      run_timeout_lb(2);
      run_instr(HLT, 3'd0, 1'b0, 1, 0);
      run_instr(RT, 3'd6, 1'b0, 0, 0);
      for (int k = 0; k < 12; k++)
         run_instr(3'($urandom_range(5)), 3'($urandom_range(4)), bit'($urandom_range(1)),
                   $urandom_range(3), $urandom_range(3));

`ifdef MC_CTRL_PERFCNT_EN
      chk("instret", int'(instret), nret % 65536);
      chk("stallcnt", int'(stallcnt), exp_stall % 65536);
`endif
      step(0);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
